data_tile_fetcher: RTL and testbench

Input-side responder to the main controller's data prepare/start/complete handshake. For one input-depth slice (`data_id_i`) it computes the slice base address, reports ready, then on start walks the feature map in overlapping 4x4 Winograd F(2x2,3x3) input tiles with stride 2. Each tile is read from the on-chip input buffer as pixel pairs and emitted as one 16-pixel word to the transform stage. `data_complete_o` is held until the next prepare.

---
 rtl/data_tile_fetcher.sv | 192 +++++++++++++++++++
 tb/tb_data_tile_fetcher.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_tile_fetcher.sv
// Input-side tile fetcher: computes the slice base on prepare, then streams overlapping
// 4x4 stride-2 input tiles read as pixel pairs from the input buffer.
module data_tile_fetcher #(
  parameter int DW     = 16,
  parameter int ADDR_W = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_wen_i,
  input  logic [8:0]          total_width_i,
  input  logic [8:0]          total_height_i,
  input  logic [3:0]          data_id_i,
  input  logic                data_prepare_i,
  input  logic                data_start_i,
  output logic                data_ready_o,
  output logic                data_complete_o,
  output logic                mem_ren_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [2*DW-1:0]     mem_rdata_i,
  output logic [16*DW-1:0]    tile_o,
  output logic                tile_valid_o,
  output logic                tile_last_o
);

  typedef enum logic [2:0] {S_IDLE, S_PREP1, S_PREP2, S_READY, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [8:0]          width_q, height_q;
  logic [3:0]          id_q;
  logic [16:0]         plane_q;
  logic [ADDR_W-1:0]   base_q, line_addr_q, tile_addr_q, row_addr_q, addr_q;
  logic [8:0]          tr_q, tc_q;
  logic [1:0]          r_q;
  logic                k_q;
  logic                start_prev_q, ren_q, ready_q, complete_q;
  logic                rd_vld_p1_q, rd_last_p1_q;
  logic [2:0]          rd_slot_p1_q;
  logic [2*DW-1:0]     work_q [7];
  logic [16*DW-1:0]    tile_q;
  logic                tile_valid_q, tile_last_q;

  logic [ADDR_W-1:0]   half_w, width_w;
  logic                start_edge, col_end, row_end, last_rd;

  assign half_w     = ADDR_W'(width_q[8:1]);
  assign width_w    = ADDR_W'(width_q);
  assign start_edge = data_start_i && !start_prev_q;
  assign col_end    = (tc_q == width_q - 9'd4);
  assign row_end    = (tr_q == height_q - 9'd4);
  assign last_rd    = (r_q == 2'd3) && k_q && col_end && row_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      id_q         <= '0;
      plane_q      <= '0;
      base_q       <= '0;
      line_addr_q  <= '0;
      tile_addr_q  <= '0;
      row_addr_q   <= '0;
      addr_q       <= '0;
      tr_q         <= '0;
      tc_q         <= '0;
      r_q          <= '0;
      k_q          <= 1'b0;
      start_prev_q <= 1'b0;
      ren_q        <= 1'b0;
      ready_q      <= 1'b0;
      complete_q   <= 1'b0;
      rd_vld_p1_q  <= 1'b0;
      rd_last_p1_q <= 1'b0;
      rd_slot_p1_q <= '0;
      tile_q       <= '0;
      tile_valid_q <= 1'b0;
      tile_last_q  <= 1'b0;
    end else begin
      start_prev_q <= data_start_i;
      tile_valid_q <= 1'b0;
      tile_last_q  <= 1'b0;

      // p1: read data returns one cycle after the read was issued
      rd_vld_p1_q  <= ren_q;
      rd_slot_p1_q <= {r_q, k_q};
      rd_last_p1_q <= ren_q && last_rd;

      // output stage: the final pair completes the tile straight from the bus
      if (rd_vld_p1_q && rd_slot_p1_q == 3'd7) begin
        tile_q       <= {mem_rdata_i, work_q[6], work_q[5], work_q[4], work_q[3],
                         work_q[2], work_q[1], work_q[0]};
        tile_valid_q <= 1'b1;
        tile_last_q  <= rd_last_p1_q;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_wen_i) begin
            width_q  <= total_width_i;
            height_q <= total_height_i;
          end
          if (data_prepare_i) begin
            id_q       <= data_id_i;
            complete_q <= 1'b0;
            state_q    <= S_PREP1;
          end
        end
        S_PREP1: begin
          plane_q <= 17'(height_q) * 17'(width_q[8:1]);
          state_q <= S_PREP2;
        end
        S_PREP2: begin
          base_q  <= ADDR_W'(id_q) * ADDR_W'(plane_q);
          ready_q <= 1'b1;
          state_q <= S_READY;
        end
        S_READY: begin
          if (start_edge) begin
            state_q     <= S_RUN;
            ready_q     <= 1'b0;
            ren_q       <= 1'b1;
            addr_q      <= base_q;
            line_addr_q <= base_q;
            tile_addr_q <= base_q;
            row_addr_q  <= base_q;
            tr_q        <= '0;
            tc_q        <= '0;
            r_q         <= '0;
            k_q         <= 1'b0;
          end else if (data_prepare_i) begin
            id_q    <= data_id_i;
            ready_q <= 1'b0;
            state_q <= S_PREP1;
          end
        end
        S_RUN: begin
          // address walk is incremental: pair, then row, then tile column, then tile row
          if (ren_q) begin
            if (!k_q) begin
              k_q    <= 1'b1;
              addr_q <= addr_q + ADDR_W'(1);
            end else if (r_q != 2'd3) begin
              r_q        <= r_q + 2'd1;
              k_q        <= 1'b0;
              addr_q     <= row_addr_q + half_w;
              row_addr_q <= row_addr_q + half_w;
            end else if (!col_end) begin
              tc_q        <= tc_q + 9'd2;
              r_q         <= '0;
              k_q         <= 1'b0;
              tile_addr_q <= tile_addr_q + ADDR_W'(1);
              row_addr_q  <= tile_addr_q + ADDR_W'(1);
              addr_q      <= tile_addr_q + ADDR_W'(1);
            end else if (!row_end) begin
              tr_q        <= tr_q + 9'd2;
              tc_q        <= '0;
              r_q         <= '0;
              k_q         <= 1'b0;
              line_addr_q <= line_addr_q + width_w;
              tile_addr_q <= line_addr_q + width_w;
              row_addr_q  <= line_addr_q + width_w;
              addr_q      <= line_addr_q + width_w;
            end else begin
              ren_q <= 1'b0;
            end
          end
          if (tile_valid_q && tile_last_q) begin
            state_q    <= S_DONE;
            complete_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // p1 capture of the first seven pairs of the tile in progress
  always_ff @(posedge clk) begin
    if (rd_vld_p1_q && rd_slot_p1_q != 3'd7) begin
      work_q[rd_slot_p1_q] <= mem_rdata_i;
    end
  end

  assign data_ready_o    = ready_q;
  assign data_complete_o = complete_q;
  assign mem_ren_o       = ren_q;
  assign mem_addr_o      = addr_q;
  assign tile_o          = tile_q;
  assign tile_valid_o    = tile_valid_q;
  assign tile_last_o     = tile_last_q;

endmodule

// File: tb/tb_data_tile_fetcher.sv
// Scoreboard bench for data_tile_fetcher: stimulus pushes expected reads/tiles with their
// cycle numbers; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_data_tile_fetcher;
  localparam int DW = 16;
  localparam int ADDR_W = 21;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_wen_i;
  logic [8:0]        total_width_i, total_height_i;
  logic [3:0]        data_id_i;
  logic              data_prepare_i, data_start_i;
  logic              data_ready_o, data_complete_o, mem_ren_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [2*DW-1:0]   mem_rdata_i = '0;
  logic [16*DW-1:0]  tile_o;
  logic              tile_valid_o, tile_last_o;

  always #5 clk = ~clk;

  data_tile_fetcher #(.DW(DW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .cfg_wen_i(cfg_wen_i),
    .total_width_i(total_width_i), .total_height_i(total_height_i),
    .data_id_i(data_id_i), .data_prepare_i(data_prepare_i), .data_start_i(data_start_i),
    .data_ready_o(data_ready_o), .data_complete_o(data_complete_o),
    .mem_ren_o(mem_ren_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .tile_o(tile_o), .tile_valid_o(tile_valid_o), .tile_last_o(tile_last_o)
  );

  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; logic [16*DW-1:0] tile; logic last; } tl_t;
  rd_t exp_rd[$];
  tl_t exp_tl[$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int tiles_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pix(input int p);
    return DW'(p * 37 + 11);
  endfunction

  function automatic logic [2*DW-1:0] word(input int a);
    return {pix(2 * a + 1), pix(2 * a)};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Input-buffer model: a read seen in one cycle returns its word in the next.
  logic pend = 1'b0;
  int   pend_addr = 0;
  always @(negedge clk) begin
    pend = mem_ren_o;
    pend_addr = int'(mem_addr_o);
  end
  always @(posedge clk) begin
    #1;
    mem_rdata_i = pend ? word(pend_addr) : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    rd_t e;
    tl_t t;
    if (!reset) begin
      if (mem_ren_o) begin
        if (exp_rd.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected: read of %0d at cycle %0d, expected no read", mem_addr_o, cyc);
        end else begin
          e = exp_rd.pop_front();
          check("rd_addr", mem_addr_o, e.addr);
          check("rd_cycle", cyc, e.cyc);
        end
      end
      if (tile_valid_o) begin
        tiles_seen++;
        if (exp_tl.size() == 0) begin
          n_chk++;
          $display("FAIL tile_unexpected: tile at cycle %0d, expected none", cyc);
        end else begin
          t = exp_tl.pop_front();
          check("tile_data", tile_o, t.tile);
          check("tile_last", tile_last_o, t.last);
          check("tile_cycle", cyc, t.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_scan(input int base, input int w, input int h, input int s);
    int n = 0;
    for (int tr = 0; tr <= h - 4; tr += 2) begin
      for (int tc = 0; tc <= w - 4; tc += 2) begin
        tl_t t;
        rd_t e;
        for (int r = 0; r < 4; r++) begin
          for (int k = 0; k < 2; k++) begin
            e.cyc = s + 1 + 8 * n + 2 * r + k;
            e.addr = base + (tr + r) * (w / 2) + tc / 2 + k;
            exp_rd.push_back(e);
          end
          for (int c = 0; c < 4; c++) t.tile[(4 * r + c) * DW +: DW] = pix(2 * base + (tr + r) * w + tc + c);
        end
        t.cyc = s + 10 + 8 * n;
        t.last = (tr == h - 4) && (tc == w - 4);
        exp_tl.push_back(t);
        n++;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_rd.size() != 0 || exp_tl.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    n_chk++;
    if (exp_rd.size() == 0 && exp_tl.size() == 0) n_pass++;
    else begin
      $display("FAIL drain: %0d reads and %0d tiles still outstanding after %0d cycles",
               exp_rd.size(), exp_tl.size(), budget);
      exp_rd.delete();
      exp_tl.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, data_ready_o, 0);
    check({tag, "_complete"}, data_complete_o, 0);
    check({tag, "_ren"}, mem_ren_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_valid"}, tile_valid_o, 0);
    check({tag, "_last"}, tile_last_o, 0);
    check({tag, "_tile"}, tile_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p, q, s, seen0;
    logic ok;
    rd_t e;
    int  d_addr[5] = '{0, 1, 4, 5, 8};
    reset = 1'b1; cfg_wen_i = 1'b0; total_width_i = '0; total_height_i = '0;
    data_id_i = '0; data_prepare_i = 1'b0; data_start_i = 1'b0;
    repeat (3) tick();
    @(negedge clk); check_zero("rst");
    tick(); reset = 1'b0;
    tick();

    // A: 4x4 map, id 0, single tile
    cfg_wen_i = 1'b1; total_width_i = 9'd4; total_height_i = 9'd4; tick(); cfg_wen_i = 1'b0;
    p = cyc; data_id_i = 4'd0; data_prepare_i = 1'b1; tick(); data_prepare_i = 1'b0;
    goto(p + 2); @(negedge clk); check("a_ready_early", data_ready_o, 0);
    goto(p + 3); @(negedge clk); check("a_ready", data_ready_o, 1);
    goto(p + 5); s = cyc; push_scan(0, 4, 4, s); data_start_i = 1'b1; tick(); data_start_i = 1'b0;
    @(negedge clk); check("a_ready_fall", data_ready_o, 0);
    goto(s + 10); @(negedge clk); check("a_complete_early", data_complete_o, 0);
    goto(s + 11); @(negedge clk); check("a_complete", data_complete_o, 1);
    check("a_ren_off", mem_ren_o, 0);
    wait_drain(20);
    ok = 1'b1;
    repeat (20) begin
      tick(); @(negedge clk);
      ok &= data_complete_o & !data_ready_o & !mem_ren_o;
    end
    check("a_complete_hold", ok, 1);

    // B: 8x6 map, id 1, base 24, six tiles
    tick(); cfg_wen_i = 1'b1; total_width_i = 9'd8; total_height_i = 9'd6; tick(); cfg_wen_i = 1'b0;
    p = cyc; data_id_i = 4'd1; data_prepare_i = 1'b1; tick(); data_prepare_i = 1'b0;
    @(negedge clk); check("b_complete_clear", data_complete_o, 0);
    goto(p + 3); @(negedge clk); check("b_ready", data_ready_o, 1);
    goto(p + 5); s = cyc; push_scan(24, 8, 6, s); data_start_i = 1'b1; tick(); data_start_i = 1'b0;
    goto(s + 50); @(negedge clk); check("b_complete_early", data_complete_o, 0);
    wait_drain(20);
    goto(s + 51); @(negedge clk); check("b_complete", data_complete_o, 1);

    // C: stale start, prepare re-latch to id 2 (base 48), ignored inputs during RUN
    tick(); p = cyc; data_id_i = 4'd5; data_prepare_i = 1'b1; data_start_i = 1'b1;
    tick(); data_prepare_i = 1'b0;
    goto(p + 3); @(negedge clk); check("c_ready", data_ready_o, 1);
    goto(p + 4); q = cyc; data_id_i = 4'd2; data_prepare_i = 1'b1; tick(); data_prepare_i = 1'b0;
    @(negedge clk); check("c_relatch_ready_drop", data_ready_o, 0);
    goto(q + 3); @(negedge clk); check("c_relatch_ready", data_ready_o, 1);
    goto(q + 6); data_start_i = 1'b0;
    @(negedge clk); check("c_stale_start", {data_ready_o, mem_ren_o}, 2'b10);
    tick(); s = cyc; push_scan(48, 8, 6, s); data_start_i = 1'b1; tick();
    @(negedge clk); check("c_ready_fall", data_ready_o, 0);
    goto(s + 3); cfg_wen_i = 1'b1; total_width_i = 9'd16; total_height_i = 9'd16;
    data_prepare_i = 1'b1; data_id_i = 4'd7;
    goto(s + 6); cfg_wen_i = 1'b0; data_prepare_i = 1'b0;
    goto(s + 50); @(negedge clk); check("c_complete_early", data_complete_o, 0);
    wait_drain(20);
    goto(s + 51); @(negedge clk); check("c_complete", data_complete_o, 1);
    data_start_i = 1'b0;

    // D: reset in the middle of the first tile of an id-0 run on the held 8x6 map
    tick(); p = cyc; data_id_i = 4'd0; data_prepare_i = 1'b1; tick(); data_prepare_i = 1'b0;
    @(negedge clk); check("d_complete_clear", data_complete_o, 0);
    goto(p + 5); s = cyc;
    for (int i = 0; i < 5; i++) begin
      e.cyc = s + 1 + i;
      e.addr = d_addr[i];
      exp_rd.push_back(e);
    end
    data_start_i = 1'b1; tick(); data_start_i = 1'b0;
    goto(s + 5); @(negedge clk);
    seen0 = tiles_seen;
    tick(); reset = 1'b1;
    @(negedge clk); check_zero("mid_rst");
    tick(); tick(); reset = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("d_no_dropped_tile", tiles_seen - seen0, 0);
    check("d_idle_ready", data_ready_o, 0);
    check("d_idle_complete", data_complete_o, 0);
    wait_drain(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
